// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, RGB payload type, renderer state
// encoding and the sprite colour-cycle table used by sprite_bounce_renderer.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_V_ACTIVE = 600;
  localparam int unsigned DEF_H_TOTAL  = 1040;
  localparam int unsigned DEF_V_TOTAL  = 666;
  localparam int unsigned COORD_W      = 11;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PAUSE = 2'd1,
    S_FLASH = 2'd2
  } state_t;

  // Colour-cycle table: red -> green -> blue.
  function automatic rgb12_t cycle_color(input logic [1:0] idx);
    case (idx)
      2'd0:    cycle_color = rgb12_t'(12'h800);
      2'd1:    cycle_color = rgb12_t'(12'h080);
      default: cycle_color = rgb12_t'(12'h008);
    endcase
  endfunction

  // Next table index, wrapping after the third entry.
  function automatic logic [1:0] next_color_idx(input logic [1:0] idx);
    next_color_idx = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/bounce_axis.sv
// bounce_axis: one axis of sprite motion. Holds the sprite's top-left
// coordinate and travel direction, moving by `step` on each step_en and
// clamping/reversing at 0 and LIMIT-SIZE.
// Ports: clk, rst (sync, active-low), step_en (advance this cycle),
//        step (pixels per advance), pos (coordinate), dir (0 = increasing,
//        1 = decreasing), flip (combinational: this advance reverses dir).
module bounce_axis
  import vga_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_H_ACTIVE,
  parameter int unsigned SIZE  = 40,
  parameter int unsigned START = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_en,
  input  logic [COORD_W-1:0] step,
  output logic [COORD_W-1:0] pos,
  output logic               dir,
  output logic               flip
);

  localparam logic [COORD_W-1:0] HI = COORD_W'(LIMIT - SIZE);

  logic               hit_c;
  logic [COORD_W-1:0] next_c;

  // Candidate next position and wall-hit detection.
  always_comb begin
    hit_c  = 1'b0;
    next_c = pos;
    if (!dir) begin
      if (pos + step >= HI) begin
        hit_c  = 1'b1;
        next_c = HI;
      end else begin
        next_c = pos + step;
      end
    end else begin
      if (pos <= step) begin
        hit_c  = 1'b1;
        next_c = '0;
      end else begin
        next_c = pos - step;
      end
    end
  end

  assign flip = step_en && hit_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pos <= COORD_W'(START);
      dir <= 1'b0;
    end else if (step_en) begin
      pos <= next_c;
      if (hit_c) dir <= ~dir;
    end
  end

endmodule

// File: rtl/sprite_bounce_renderer.sv
// sprite_bounce_renderer: pixel-colour stage behind the 800x600 VGA timing
// counters. Draws a square sprite that moves once per frame, bounces off the
// active-area edges, and flashes white for a number of frames after hitting
// a corner. Motion can be frozen with the level-sensitive pause input.
// Ports: clk, rst (sync, active-low), pxl_en (pixel-clock enable),
//        colpxl/linepxl (current column/line), pause,
//        red/green/blue (registered 4-bit colour, 1 clk after coordinates),
//        bounce_x/bounce_y (one-clk direction-flip pulses),
//        flash_active (corner flash in progress).
// Optional: define SPRITE_COLOR_CYCLE_EN to step the sprite colour through
// red/green/blue on every update that produces a bounce.
module sprite_bounce_renderer
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
  parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
  parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
  parameter int unsigned SIZE         = 40,
  parameter int unsigned STEP         = 4,
  parameter int unsigned X0           = 100,
  parameter int unsigned Y0           = 100,
  parameter int unsigned FLASH_FRAMES = 30,
  parameter logic [11:0] SPRITE_COLOR = 12'h800,
  parameter logic [11:0] BG_COLOR     = 12'h000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pxl_en,
  input  logic [COORD_W-1:0] colpxl,
  input  logic [COORD_W-1:0] linepxl,
  input  logic               pause,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               bounce_x,
  output logic               bounce_y,
  output logic               flash_active
);

  localparam int unsigned FLASH_W     = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam rgb12_t      FLASH_COLOR = rgb12_t'(12'hFFF);

  logic               fu_c;
  logic               step_en_c;
  logic [COORD_W-1:0] x_pos;
  logic [COORD_W-1:0] y_pos;
  logic               flip_x;
  logic               flip_y;
  logic               unused_dir_x;
  logic               unused_dir_y;
  state_t             state;
  logic [FLASH_W-1:0] flash_cnt;
  rgb12_t             sprite_col_c;
  rgb12_t             pix_c;
  rgb12_t             pix;
  logic               in_active_c;
  logic               in_sprite_c;

  // Frame update strobe: last pixel of the last line.
  assign fu_c = pxl_en && (colpxl == COORD_W'(H_TOTAL - 1))
                       && (linepxl == COORD_W'(V_TOTAL - 1));
  assign step_en_c = fu_c && (state == S_RUN);

  bounce_axis #(.LIMIT(H_ACTIVE), .SIZE(SIZE), .START(X0)) u_axis_x (
    .clk     (clk),
    .rst     (rst),
    .step_en (step_en_c),
    .step    (COORD_W'(STEP)),
    .pos     (x_pos),
    .dir     (unused_dir_x),
    .flip    (flip_x)
  );

  bounce_axis #(.LIMIT(V_ACTIVE), .SIZE(SIZE), .START(Y0)) u_axis_y (
    .clk     (clk),
    .rst     (rst),
    .step_en (step_en_c),
    .step    (COORD_W'(STEP)),
    .pos     (y_pos),
    .dir     (unused_dir_y),
    .flip    (flip_y)
  );

`ifdef SPRITE_COLOR_CYCLE_EN
  logic [1:0] color_idx;

  // A corner hit flips both axes in one update but advances only once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      color_idx <= 2'd0;
    end else if (flip_x || flip_y) begin
      color_idx <= next_color_idx(color_idx);
    end
  end

  assign sprite_col_c = cycle_color(color_idx);
`else
  assign sprite_col_c = rgb12_t'(SPRITE_COLOR);
`endif

  // Pixel colour for the current coordinates.
  always_comb begin
    in_active_c = (colpxl < COORD_W'(H_ACTIVE)) && (linepxl < COORD_W'(V_ACTIVE));
    in_sprite_c = (colpxl >= x_pos) && (colpxl < x_pos + COORD_W'(SIZE))
               && (linepxl >= y_pos) && (linepxl < y_pos + COORD_W'(SIZE));
    pix_c = '0;
    if (in_active_c) begin
      if (in_sprite_c) pix_c = (state == S_FLASH) ? FLASH_COLOR : sprite_col_c;
      else             pix_c = rgb12_t'(BG_COLOR);
    end
  end

  // Run/pause/flash control, pulses and colour register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_RUN;
      flash_cnt    <= '0;
      flash_active <= 1'b0;
      bounce_x     <= 1'b0;
      bounce_y     <= 1'b0;
      pix          <= '0;
    end else begin
      bounce_x <= flip_x;
      bounce_y <= flip_y;
      pix      <= pix_c;
      if (fu_c) begin
        case (state)
          S_RUN: begin
            if (flip_x && flip_y) begin
              state        <= S_FLASH;
              flash_cnt    <= FLASH_W'(FLASH_FRAMES - 1);
              flash_active <= 1'b1;
            end else if (pause) begin
              state <= S_PAUSE;
            end
          end
          S_PAUSE: begin
            if (!pause) state <= S_RUN;
          end
          S_FLASH: begin
            if (flash_cnt == '0) begin
              state        <= pause ? S_PAUSE : S_RUN;
              flash_active <= 1'b0;
            end else begin
              flash_cnt <= flash_cnt - FLASH_W'(1);
            end
          end
          default: begin
            state        <= S_RUN;
            flash_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign red   = pix.r;
  assign green = pix.g;
  assign blue  = pix.b;

endmodule

// File: tb/tb_sprite_bounce_renderer.sv
// Bench for sprite_bounce_renderer: two instances (default start and a start
// near the bottom-right corner) share stimulus; a frame-level model of the
// sprite tracks position, velocity, pause and flash for each.
module tb_sprite_bounce_renderer;

  localparam int HA = 800;
  localparam int VA = 600;
  localparam int HT = 1040;
  localparam int VT = 666;
  localparam int SZ = 40;
  localparam int ST = 4;
  localparam int FF = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        pxl_en;
  logic [10:0] colpxl;
  logic [10:0] linepxl;
  logic        pause;

  logic [3:0] red0, green0, blue0, red1, green1, blue1;
  logic       bounce_x0, bounce_y0, flash_active0;
  logic       bounce_x1, bounce_y1, flash_active1;

  sprite_bounce_renderer dut0 (
    .clk(clk), .rst(rst), .pxl_en(pxl_en), .colpxl(colpxl), .linepxl(linepxl),
    .pause(pause), .red(red0), .green(green0), .blue(blue0),
    .bounce_x(bounce_x0), .bounce_y(bounce_y0), .flash_active(flash_active0)
  );

  sprite_bounce_renderer #(.X0(720), .Y0(520)) dut1 (
    .clk(clk), .rst(rst), .pxl_en(pxl_en), .colpxl(colpxl), .linepxl(linepxl),
    .pause(pause), .red(red1), .green(green1), .blue(blue1),
    .bounce_x(bounce_x1), .bounce_y(bounce_y1), .flash_active(flash_active1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Frame-level sprite model per instance.
  int x0s[2] = '{100, 720};
  int y0s[2] = '{100, 520};
  int mx[2], my[2], vx[2], vy[2], flash_left[2], cidx[2];
  bit paused[2];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = x0s[i]; my[i] = y0s[i];
      vx[i] = 1;      vy[i] = 1;
      flash_left[i] = 0; cidx[i] = 0; paused[i] = 1'b0;
    end
  endtask

  function automatic int sprite_col(input int i);
`ifdef SPRITE_COLOR_CYCLE_EN
    case (cidx[i] % 3)
      0:       return 'h800;
      1:       return 'h080;
      default: return 'h008;
    endcase
`else
    return 'h800 + 0 * i;
`endif
  endfunction

  function automatic int model_pix(input int i, input int col, input int line);
    if (col >= HA || line >= VA) return 0;
    if (col >= mx[i] && col < mx[i] + SZ && line >= my[i] && line < my[i] + SZ)
      return (flash_left[i] > 0) ? 'hFFF : sprite_col(i);
    return 0;
  endfunction

  // One frame update for instance i with pause level p.
  task automatic model_frame(input int i, input bit p, output bit bx, output bit by);
    int t;
    bx = 1'b0; by = 1'b0;
    if (flash_left[i] > 0) begin
      flash_left[i]--;
      if (flash_left[i] == 0) paused[i] = p;
    end else if (paused[i]) begin
      paused[i] = p;
    end else begin
      t = mx[i] + vx[i] * ST;
      if ((vx[i] > 0 && t >= HA - SZ) || (vx[i] < 0 && t <= 0)) begin
        mx[i] = (vx[i] > 0) ? HA - SZ : 0; vx[i] = -vx[i]; bx = 1'b1;
      end else mx[i] = t;
      t = my[i] + vy[i] * ST;
      if ((vy[i] > 0 && t >= VA - SZ) || (vy[i] < 0 && t <= 0)) begin
        my[i] = (vy[i] > 0) ? VA - SZ : 0; vy[i] = -vy[i]; by = 1'b1;
      end else my[i] = t;
      if (bx && by) flash_left[i] = FF;
      else          paused[i] = p;
      if (bx || by) cidx[i]++;
    end
  endtask

  task automatic probe(input int col, input int line);
    colpxl  = 11'(col);
    linepxl = 11'(line);
    pxl_en  = 1'($urandom_range(0, 1));
    if (colpxl == 11'(HT - 1) && linepxl == 11'(VT - 1)) pxl_en = 1'b0;
    tick();
    check("rgb0", 16'({red0, green0, blue0}), 16'(model_pix(0, int'(colpxl), int'(linepxl))));
    check("rgb1", 16'({red1, green1, blue1}), 16'(model_pix(1, int'(colpxl), int'(linepxl))));
  endtask

  task automatic probe_sprites();
    for (int i = 0; i < 2; i++) begin
      probe(mx[i], my[i]);
      probe(mx[i] - 1, my[i]);
      probe(mx[i] + SZ - 1, my[i] + SZ - 1);
      probe(mx[i] + SZ, my[i] + SZ - 1);
      probe(mx[i] + SZ - 1, my[i] + SZ);
    end
    probe($urandom_range(0, HT - 1), $urandom_range(0, VT - 2));
  endtask

  task automatic do_frame(input bit p);
    bit ebx[2], eby[2];
    pause   = p;
    pxl_en  = 1'b1;
    colpxl  = 11'(HT - 1);
    linepxl = 11'(VT - 1);
    tick();
    for (int i = 0; i < 2; i++) model_frame(i, p, ebx[i], eby[i]);
    check("bounce_x0", 16'(bounce_x0), 16'(ebx[0]));
    check("bounce_y0", 16'(bounce_y0), 16'(eby[0]));
    check("bounce_x1", 16'(bounce_x1), 16'(ebx[1]));
    check("bounce_y1", 16'(bounce_y1), 16'(eby[1]));
    check("flash0", 16'(flash_active0), 16'(flash_left[0] > 0));
    check("flash1", 16'(flash_active1), 16'(flash_left[1] > 0));
    pxl_en  = 1'b1;
    colpxl  = 11'($urandom_range(0, HT - 1));
    linepxl = 11'($urandom_range(0, VT - 2));
    tick();
    check("pulse_end", 16'({bounce_x0, bounce_y0, bounce_x1, bounce_y1}), 16'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; pxl_en = 1'b0; colpxl = '0; linepxl = '0; pause = 1'b0;
    model_reset();
    repeat (5) tick();
    check("reset_rgb0", 16'({red0, green0, blue0}), 16'(0));
    check("reset_rgb1", 16'({red1, green1, blue1}), 16'(0));
    check("reset_pulses", 16'({bounce_x0, bounce_y0, bounce_x1, bounce_y1}), 16'(0));
    check("reset_flash", 16'({flash_active0, flash_active1}), 16'(0));
    rst = 1'b1;

    // Directed pixels around the reset sprite and blanking.
    probe(120, 120);
    probe(140, 120);
    probe(900, 120);
    probe(120, 610);
    probe_sprites();

    // Partial strobes must not move the sprite.
    pxl_en = 1'b1; colpxl = 11'(HT - 1); linepxl = 11'(VT - 2); tick();
    pxl_en = 1'b0; colpxl = 11'(HT - 1); linepxl = 11'(VT - 1); tick();
    probe_sprites();

    // Pause raised before the third update, held for five more frames.
    do_frame(1'b0); do_frame(1'b0); do_frame(1'b1);
    probe(112, 100);
    probe(111, 100);
    repeat (5) begin do_frame(1'b1); probe_sprites(); end
    do_frame(1'b0); probe_sprites();
    do_frame(1'b0); probe_sprites();

    // Advance until the corner instance is mid-flash, then reset mid-frame.
    for (int k = 0; k < 100 && !(flash_left[1] > 0 && flash_left[1] <= 20); k++) begin
      do_frame(1'b0);
      probe_sprites();
    end
    check("flash1_before_reset", 16'(flash_active1), 16'(1));
    colpxl = 11'd400; linepxl = 11'd300; pxl_en = 1'b1; rst = 1'b0;
    tick();
    model_reset();
    check("midreset_flash", 16'({flash_active0, flash_active1}), 16'(0));
    check("midreset_rgb1", 16'({red1, green1, blue1}), 16'(0));
    check("midreset_pulses", 16'({bounce_x0, bounce_y0, bounce_x1, bounce_y1}), 16'(0));
    rst = 1'b1;
    probe(120, 120);
    probe_sprites();

    // Long run: full corner flash (pause ignored during it, honoured at its
    // end) and the default instance's right-wall bounce.
    for (int k = 0; k < 200; k++) begin
      do_frame(((k >= 15 && k < 20) || (k >= 36 && k <= 41)) ? 1'b1 : 1'b0);
      probe_sprites();
    end

    // Random pause pattern.
    for (int k = 0; k < 150; k++) begin
      do_frame(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      probe_sprites();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
